// File: rtl/pe_dot_sequencer.sv
// Dot-product job sequencer: streams paired reads to the memory reader, gates the
// PE accumulate enable in step with returning data, then returns the PE result.
module pe_dot_sequencer #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic              pe_active,
    output logic              pe_clear,
    input  logic              pe_out_empty,
    input  logic [DATA_W-1:0] pe_out,
    output logic              pe_read,
    output logic [DATA_W-1:0] result,
    output logic              result_err,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int unsigned       TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned       LW    = $clog2(MEM_LAT + 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);
    localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0]     LLAST = LW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ALIGN,
        DRAIN,
        HOLD
    } state_t;

    state_t             state;
    logic [15:0]        len_q;
    logic [15:0]        cnt;
    logic [LW-1:0]      acnt;
    logic [TW-1:0]      tcnt;
    logic               first_q;
    logic [MEM_LAT-1:0] en_sr;
    logic [MEM_LAT-1:0] clr_sr;
    logic [MEM_LAT:0]   en_next;
    logic [MEM_LAT:0]   clr_next;

    // The shift registers are MEM_LAT deep; building the next value one bit wider
    // keeps the shift expression valid for MEM_LAT == 1.
    assign en_next   = {en_sr, mem_en};
    assign clr_next  = {clr_sr, first_q};
    assign pe_active = en_sr[MEM_LAT-1];
    assign pe_clear  = clr_sr[MEM_LAT-1];
    assign pe_read   = (state == DRAIN) && !pe_out_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            mem_en       <= 1'b0;
            addr1        <= '0;
            addr2        <= '0;
            result       <= '0;
            result_err   <= 1'b0;
            result_valid <= 1'b0;
            len_q        <= '0;
            cnt          <= '0;
            acnt         <= '0;
            tcnt         <= '0;
            first_q      <= 1'b0;
            en_sr        <= '0;
            clr_sr       <= '0;
        end else begin
            en_sr   <= en_next[MEM_LAT-1:0];
            clr_sr  <= clr_next[MEM_LAT-1:0];
            first_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        first_q <= 1'b1;
                        addr1   <= base_a;
                        addr2   <= base_b;
                        len_q   <= len;
                        cnt     <= 16'd1;
                    end
                end
                ISSUE: begin
                    // cnt holds the number of reads already issued
                    if (cnt == len_q) begin
                        mem_en <= 1'b0;
                        acnt   <= '0;
                        state  <= ALIGN;
                    end else begin
                        addr1 <= addr1 + STEP;
                        addr2 <= addr2 + STEP;
                        cnt   <= cnt + 16'd1;
                    end
                end
                ALIGN: begin
                    if (acnt == LLAST) begin
                        tcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        acnt <= acnt + LW'(1);
                    end
                end
                DRAIN: begin
                    if (!pe_out_empty) begin
                        result       <= pe_out;
                        result_err   <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end else if (tcnt == TLAST) begin
                        result       <= '0;
                        result_err   <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Bench for pe_dot_sequencer: a job-timeline model checked every cycle against two
// instances (MEM_LAT 1 and 3), plus directed literal checks.
module tb_pe_dot_sequencer;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [15:0] len;
    logic [31:0] base_a, base_b;
    logic        pe_out_empty;
    logic [31:0] pe_out;
    logic        result_ready;

    logic        busy_w[2], mem_en_w[2], pe_active_w[2], pe_clear_w[2];
    logic        pe_read_w[2], result_err_w[2], result_valid_w[2];
    logic [31:0] addr1_w[2], addr2_w[2], result_w[2];

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pe_dot_sequencer #(.MEM_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .len(len), .base_a(base_a), .base_b(base_b),
        .busy(busy_w[0]), .mem_en(mem_en_w[0]), .addr1(addr1_w[0]), .addr2(addr2_w[0]),
        .pe_active(pe_active_w[0]), .pe_clear(pe_clear_w[0]), .pe_out_empty(pe_out_empty),
        .pe_out(pe_out), .pe_read(pe_read_w[0]), .result(result_w[0]),
        .result_err(result_err_w[0]), .result_valid(result_valid_w[0]),
        .result_ready(result_ready)
    );

    pe_dot_sequencer #(.MEM_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .len(len), .base_a(base_a), .base_b(base_b),
        .busy(busy_w[1]), .mem_en(mem_en_w[1]), .addr1(addr1_w[1]), .addr2(addr2_w[1]),
        .pe_active(pe_active_w[1]), .pe_clear(pe_clear_w[1]), .pe_out_empty(pe_out_empty),
        .pe_out(pe_out), .pe_read(pe_read_w[1]), .result(result_w[1]),
        .result_err(result_err_w[1]), .result_valid(result_valid_w[1]),
        .result_ready(result_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Job model: everything follows from the accept edge t0, the job length, the
    // read latency and the observed pe_out_empty history.
    int          lat[2] = '{1, 3};
    bit          job[2], hold[2];
    int          t0[2], jl[2];
    logic [31:0] ja[2], jb[2];
    logic [31:0] e_a1[2], e_a2[2], e_res[2];
    bit          e_err[2], e_mem[2], e_act[2], e_clr[2], e_drain[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            job[i] = 0; hold[i] = 0; t0[i] = 0; jl[i] = 0; ja[i] = 0; jb[i] = 0;
            e_a1[i] = 0; e_a2[i] = 0; e_res[i] = 0; e_err[i] = 0;
            e_mem[i] = 0; e_act[i] = 0; e_clr[i] = 0; e_drain[i] = 0;
        end
    end

    always @(posedge clk) begin
        int  kp, k, d;
        logic stv;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            stv = (i == 0) ? start0 : start1;
            if (rst) begin
                job[i] = 0; hold[i] = 0;
                e_a1[i] = 0; e_a2[i] = 0; e_res[i] = 0; e_err[i] = 0;
            end else if (!job[i]) begin
                if (stv && len != 0) begin
                    job[i] = 1; t0[i] = cyc; jl[i] = int'(len); ja[i] = base_a; jb[i] = base_b;
                end
            end else if (hold[i]) begin
                if (result_ready) begin
                    job[i] = 0; hold[i] = 0;
                end
            end else begin
                kp = cyc - t0[i];
                if (kp >= jl[i] + lat[i] + 1) begin
                    d = kp - (jl[i] + lat[i] + 1);
                    if (!pe_out_empty) begin
                        hold[i] = 1; e_res[i] = pe_out; e_err[i] = 0;
                    end else if (d == TMO - 1) begin
                        hold[i] = 1; e_res[i] = 0; e_err[i] = 1;
                    end
                end
            end
            k = cyc - t0[i] + 1;
            e_mem[i]   = job[i] && !hold[i] && k >= 1 && k <= jl[i];
            e_act[i]   = job[i] && !hold[i] && k >= lat[i] + 1 && k <= jl[i] + lat[i];
            e_clr[i]   = job[i] && !hold[i] && k == lat[i] + 1;
            e_drain[i] = job[i] && !hold[i] && k >= jl[i] + lat[i] + 1;
            if (e_mem[i]) begin
                e_a1[i] = ja[i] + 32'((k - 1) * 4);
                e_a2[i] = jb[i] + 32'((k - 1) * 4);
            end
        end
    end

    int rd_cnt[2] = '{0, 0};
    int men_cnt[2] = '{0, 0};
    int hs_cnt[2] = '{0, 0};

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), busy_w[i], job[i]);
                chk($sformatf("mem_en[%0d]", i), mem_en_w[i], e_mem[i]);
                chk($sformatf("addr1[%0d]", i), addr1_w[i], e_a1[i]);
                chk($sformatf("addr2[%0d]", i), addr2_w[i], e_a2[i]);
                chk($sformatf("pe_active[%0d]", i), pe_active_w[i], e_act[i]);
                chk($sformatf("pe_clear[%0d]", i), pe_clear_w[i], e_clr[i]);
                chk($sformatf("pe_read[%0d]", i), pe_read_w[i], e_drain[i] && !pe_out_empty);
                chk($sformatf("result_valid[%0d]", i), result_valid_w[i], job[i] && hold[i]);
                chk($sformatf("result[%0d]", i), result_w[i], e_res[i]);
                chk($sformatf("result_err[%0d]", i), result_err_w[i], e_err[i]);
                rd_cnt[i]  += int'(pe_read_w[i] === 1'b1);
                men_cnt[i] += int'(mem_en_w[i] === 1'b1);
                hs_cnt[i]  += int'(result_valid_w[i] === 1'b1 && result_ready === 1'b1);
            end
        end
    end

    task automatic wait_valid(input int i, input int budget, output int n);
        n = 0;
        while (result_valid_w[i] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("wait_valid[%0d]", i), result_valid_w[i], 1'b1);
    endtask

    initial begin
        int n, r0, h0, m0;
        rst = 1; start0 = 0; start1 = 0; len = 0; base_a = 0; base_b = 0;
        pe_out_empty = 1; pe_out = 0; result_ready = 1;
        tick(); tick();
        rst = 0;
        chk("reset_busy", busy_w[0], 1'b0);
        chk("reset_mem_en", mem_en_w[0], 1'b0);
        chk("reset_valid", result_valid_w[0], 1'b0);
        chk("reset_active", pe_active_w[1], 1'b0);
        tick();

        // Basic job, result 3 cycles into DRAIN
        r0 = rd_cnt[0];
        len = 4; base_a = 0; base_b = 8; pe_out = 32'h1234; start0 = 1;
        tick(); start0 = 0;
        chk("t1_busy", busy_w[0], 1'b1);
        for (int j = 0; j < 4; j++) begin
            chk("t1_addr1", addr1_w[0], 32'(j * 4));
            chk("t1_addr2", addr2_w[0], 32'(8 + j * 4));
            chk("t1_mem_en", mem_en_w[0], 1'b1);
            chk("t1_clear", pe_clear_w[0], j == 1);
            chk("t1_active", pe_active_w[0], j >= 1);
            tick();
        end
        chk("t1_mem_off", mem_en_w[0], 1'b0);
        chk("t1_active_last", pe_active_w[0], 1'b1);
        tick();
        chk("t1_active_end", pe_active_w[0], 1'b0);
        tick(); tick(); tick();
        pe_out_empty = 0;
        #1 chk("t1_pe_read", pe_read_w[0], 1'b1);
        tick();
        pe_out_empty = 1;
        chk("t1_valid", result_valid_w[0], 1'b1);
        chk("t1_result", result_w[0], 32'h1234);
        chk("t1_err", result_err_w[0], 1'b0);
        tick();
        chk("t1_busy_low", busy_w[0], 1'b0);
        chk("t1_read_count", rd_cnt[0] - r0, 1);

        // Backpressure
        h0 = hs_cnt[0];
        result_ready = 0; pe_out = 32'h5A5A; pe_out_empty = 0;
        len = 4; base_a = 0; base_b = 8; start0 = 1;
        tick(); start0 = 0;
        wait_valid(0, 40, n);
        pe_out_empty = 1;
        for (int j = 0; j < 5; j++) begin
            chk("bp_valid", result_valid_w[0], 1'b1);
            chk("bp_result", result_w[0], 32'h5A5A);
            tick();
        end
        result_ready = 1;
        chk("bp_valid_ready", result_valid_w[0], 1'b1);
        tick();
        chk("bp_valid_clear", result_valid_w[0], 1'b0);
        tick();
        chk("bp_handshakes", hs_cnt[0] - h0, 1);

        // len = 0 is ignored
        len = 0; start0 = 1;
        tick(); start0 = 0;
        chk("len0_busy", busy_w[0], 1'b0);
        tick();
        chk("len0_busy2", busy_w[0], 1'b0);

        // Start while busy is ignored
        m0 = men_cnt[0];
        len = 4; base_a = 32'h100; base_b = 32'h200; start0 = 1;
        tick(); start0 = 0;
        tick();
        len = 9; base_a = 32'h900; start0 = 1;
        tick(); start0 = 0;
        chk("mid_addr1", addr1_w[0], 32'h108);
        pe_out = 32'h42; pe_out_empty = 0;
        wait_valid(0, 40, n);
        pe_out_empty = 1;
        tick(); tick();
        chk("mid_mem_en_count", men_cnt[0] - m0, 4);
        chk("mid_busy", busy_w[0], 1'b0);

        // Timeout
        r0 = rd_cnt[0];
        len = 1; base_a = 32'h40; base_b = 32'h80; pe_out_empty = 1; start0 = 1;
        tick(); start0 = 0;
        n = 1;
        while (result_valid_w[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("to_latency", n, 67);
        chk("to_valid", result_valid_w[0], 1'b1);
        chk("to_err", result_err_w[0], 1'b1);
        chk("to_result", result_w[0], 32'h0);
        chk("to_no_read", rd_cnt[0] - r0, 0);
        tick(); tick();
        chk("to_busy", busy_w[0], 1'b0);

        // Address wrap and MEM_LAT = 3
        len = 2; base_a = 32'hFFFF_FFFC; base_b = 32'h10; pe_out = 32'hBEEF; start1 = 1;
        tick(); start1 = 0;
        chk("wr_addr1_0", addr1_w[1], 32'hFFFF_FFFC);
        chk("wr_active_1", pe_active_w[1], 1'b0);
        tick();
        chk("wr_addr1_1", addr1_w[1], 32'h0);
        chk("wr_addr2_1", addr2_w[1], 32'h14);
        tick();
        chk("wr_mem_off", mem_en_w[1], 1'b0);
        chk("wr_active_3", pe_active_w[1], 1'b0);
        tick();
        chk("wr_active_4", pe_active_w[1], 1'b1);
        chk("wr_clear_4", pe_clear_w[1], 1'b1);
        tick();
        chk("wr_active_5", pe_active_w[1], 1'b1);
        chk("wr_clear_5", pe_clear_w[1], 1'b0);
        tick();
        chk("wr_active_6", pe_active_w[1], 1'b0);
        pe_out_empty = 0;
        wait_valid(1, 20, n);
        pe_out_empty = 1;
        chk("wr_result", result_w[1], 32'hBEEF);
        tick(); tick();
        chk("wr_busy", busy_w[1], 1'b0);

        // Reset during ISSUE, then a normal len = 1 job
        len = 4; base_a = 32'h80; base_b = 32'hC0; start0 = 1;
        tick(); start0 = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rs_busy", busy_w[0], 1'b0);
        chk("rs_mem_en", mem_en_w[0], 1'b0);
        chk("rs_addr1", addr1_w[0], 32'h0);
        chk("rs_addr2", addr2_w[0], 32'h0);
        chk("rs_result", result_w[0], 32'h0);
        chk("rs_valid", result_valid_w[0], 1'b0);
        for (int j = 0; j < 4; j++) begin
            chk("rs_active", pe_active_w[0], 1'b0);
            tick();
        end
        len = 1; base_a = 32'h20; base_b = 32'h30; pe_out = 32'h77; pe_out_empty = 0; start0 = 1;
        tick(); start0 = 0;
        chk("rs2_addr1", addr1_w[0], 32'h20);
        chk("rs2_mem_en", mem_en_w[0], 1'b1);
        wait_valid(0, 20, n);
        pe_out_empty = 1;
        chk("rs2_result", result_w[0], 32'h77);
        tick(); tick();
        chk("rs2_busy", busy_w[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pe_dot_sequencer.md
# pe_dot_sequencer

Sequences one dot-product job through the memory reader and a single processing element. Given base addresses and a length, it issues one paired read per cycle to the memory reader, gates the PE's `active` input in step with the returning data, waits for the PE result, and returns it on a valid/ready handshake. It sits between the job-dispatch logic and the Memory_Reader / ProcessingElementMod pair.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both read ports
- `DATA_W`, 32, width of the PE result
- `ADDR_STEP`, 4, byte increment between consecutive elements
- `MEM_LAT`, 1, memory reader read latency in cycles (1..4)
- `TIMEOUT`, 64, maximum DRAIN cycles before an error completion

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  job request, sampled only in IDLE
- `len`  in  16  number of element pairs, sampled with `start`
- `base_a`  in  ADDR_W  first address of operand A, sampled with `start`
- `base_b`  in  ADDR_W  first address of operand B, sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` until the result handshake completes
- `mem_en`  out  1  read enable to the memory reader
- `addr1`  out  ADDR_W  operand A read address
- `addr2`  out  ADDR_W  operand B read address
- `pe_active`  out  1  PE accumulate enable, aligned to returning data
- `pe_clear`  out  1  one-cycle accumulator clear, coincident with the first `pe_active`
- `pe_out_empty`  in  1  PE output empty flag, low = result available
- `pe_out`  in  DATA_W  PE result
- `pe_read`  out  1  one-cycle pop of the PE output
- `result`  out  DATA_W  captured result
- `result_err`  out  1  set with `result_valid` on timeout
- `result_valid`  out  1  result available
- `result_ready`  in  1  consumer accepts the result

## Operation
- States:
  - IDLE
    - `start` with `len`≠0 captures `len`, `base_a`, `base_b` → ISSUE.
    - `start` with `len`=0 is ignored, and `busy` stays 0.
  - ISSUE
    - Each cycle: `mem_en`=1, `addr1`=base_a+i·ADDR_STEP, `addr2`=base_b+i·ADDR_STEP, for i=0..len−1.
    - After i=len−1 → ALIGN.
  - ALIGN
    - Lasts MEM_LAT cycles while the enable pipeline drains.
    - Then → DRAIN.
  - DRAIN
    - Each cycle where `pe_out_empty`=0:
      - `pe_read`=1 for that cycle;
      - `result`←`pe_out`, `result_err`←0, `result_valid`←1;
      - → HOLD.
    - If TIMEOUT cycles pass in DRAIN without this: `result`←0, `result_err`←1, `result_valid`←1, → HOLD. No `pe_read` is issued.
  - HOLD
    - `result_valid` held, with `result` and `result_err` stable.
    - On `result_valid`&&`result_ready` → IDLE. `result_valid` clears on the next edge.
- `pe_active` is `mem_en` delayed by exactly MEM_LAT cycles through a shift register. `pe_clear` is the delayed first-issue marker.
- Address arithmetic is modulo 2^ADDR_W (wrap-around, no flag). The element counter is 16 bits, so len ≤ 65535.
- `start` while `busy` is ignored and does not alter captured values.
- `addr1`/`addr2` hold their last value when `mem_en`=0.

## Timing
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The enable/clear shift register and the timeout counter are cleared.
  - Reset asserted mid-job aborts the job with no result, and any in-flight `pe_active` is dropped.
- `start` sampled at edge T0:
  - `busy`=1 and the first `mem_en` at cycle T0+1.
  - The last `mem_en` at T0+len.
  - `pe_active` is high during T0+1+MEM_LAT .. T0+len+MEM_LAT.
  - `pe_clear` at T0+1+MEM_LAT.
- DRAIN is entered at T0+len+MEM_LAT+1.
- When `pe_out_empty` is seen low in cycle Tx, `pe_read` is high in Tx and `result_valid` rises at Tx+1.
- `busy` falls in the cycle after the handshake. A new `start` is accepted in that same cycle (IDLE).
- `pe_out_empty` low during ISSUE/ALIGN is ignored; it is evaluated only in DRAIN.

## Test plan
- len=4, base_a=0, base_b=8, MEM_LAT=1; PE model drives `pe_out`=0x1234 with `pe_out_empty` low 3 cycles into DRAIN, `result_ready`=1 → expected:
  - `addr1` 0,4,8,12 and `addr2` 8,12,16,20 on T0+1..T0+4;
  - `pe_active` T0+2..T0+5, `pe_clear` only at T0+2;
  - one `pe_read` pulse, `result`=0x1234, `result_err`=0, `busy` low afterwards.
- Backpressure: same job with `result_ready` low for 5 cycles → `result_valid` is held 5+ cycles with `result` stable, completing exactly once when ready rises.
- `start` with len=0, and a second `start` (len=9) issued mid-ISSUE of a len=4 job → expected:
  - len=0: `busy` stays 0.
  - len=9: ignored, exactly 4 `mem_en` cycles.
- Timeout: `pe_out_empty` held 1 → `result_valid`=1, `result_err`=1, `result`=0 at DRAIN entry+64, no `pe_read`.
- Wrap and latency: base_a=0xFFFFFFFC, len=2, MEM_LAT=3 → `addr1` 0xFFFFFFFC then 0x00000000, and `pe_active` lags `mem_en` by 3 cycles.
- `rst` pulsed during cycle 2 of ISSUE → all outputs 0 on the next edge, no further `pe_active`; a following len=1 job runs normally.
